// File: rtl/glay_kernel_request_arbiter_if.sv
// Request/grant bus between the request sources, the arbiter and the request-out FIFO.
// master: arbiter side; slave: the sources plus the FIFO that consumes the registered packet.
interface glay_kernel_request_arbiter_if #(
  parameter int NUM_REQUESTERS = 4,
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS),
  parameter int PAYLOAD_WIDTH  = 64
);
  logic [NUM_REQUESTERS-1:0]                    arbiter_req_in_valid;
  logic [NUM_REQUESTERS-1:0][PAYLOAD_WIDTH-1:0] arbiter_req_in_payload;
  logic [NUM_REQUESTERS-1:0]                    arbiter_grant_out;
  logic                                         arbiter_req_out_valid;
  logic [PAYLOAD_WIDTH-1:0]                     arbiter_req_out_payload;
  logic [ID_WIDTH-1:0]                          arbiter_req_out_id;

  modport master (
    input  arbiter_req_in_valid,
    input  arbiter_req_in_payload,
    output arbiter_grant_out,
    output arbiter_req_out_valid,
    output arbiter_req_out_payload,
    output arbiter_req_out_id
  );

  modport slave (
    output arbiter_req_in_valid,
    output arbiter_req_in_payload,
    input  arbiter_grant_out,
    input  arbiter_req_out_valid,
    input  arbiter_req_out_payload,
    input  arbiter_req_out_id
  );
endinterface

// File: rtl/glay_kernel_request_arbiter.sv
// Round-robin arbiter sharing one cache request channel between kernel request sources.
// Optional per-source saturating grant counters are built when GLAY_ARBITER_STATS_EN is defined.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// ARB_RESET | leaving reset, no grants
// ARB_IDLE  | arbitration disabled or FIFO setup in progress, no grants
// ARB_BUSY  | granting, subject to prog_full / fifo setup backpressure
module glay_kernel_request_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS),
  parameter int COUNTER_WIDTH  = 32
) (
  input  logic                     ap_clk,
  input  logic                     areset,
  glay_kernel_request_arbiter_if.master arb,
  input  logic                     downstream_prog_full,
  input  logic                     fifo_setup_signal,
  input  logic                     arbiter_enable,
  output logic                     arbiter_idle,
  output logic [COUNTER_WIDTH-1:0] arbiter_grant_count [NUM_REQUESTERS]
);

  typedef enum logic [1:0] {
    ARB_RESET = 2'd0,
    ARB_IDLE  = 2'd1,
    ARB_BUSY  = 2'd2
  } arb_state_t;

  arb_state_t                state_q;
  arb_state_t                state_d;
  logic [ID_WIDTH-1:0]       last_grant_q;
  logic [ID_WIDTH-1:0]       winner;
  logic [ID_WIDTH-1:0]       cand;
  logic [NUM_REQUESTERS-1:0] grant_vec;
  logic                      grant_any;
  logic                      can_grant;
  logic                      out_valid_q;
  logic [ID_WIDTH-1:0]       out_id_q;
  logic                      idle_q;

  always_ff @(posedge ap_clk) begin
    if (areset) state_q <= ARB_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_RESET: state_d = ARB_IDLE;
      ARB_IDLE:  if (arbiter_enable && !fifo_setup_signal) state_d = ARB_BUSY;
      ARB_BUSY:  if (!arbiter_enable || fifo_setup_signal) state_d = ARB_IDLE;
      default:   state_d = ARB_RESET;
    endcase
  end

  // Search starts one past the last winner; the first valid source found wins.
  always_comb begin
    can_grant = (state_q == ARB_BUSY) & ~downstream_prog_full & ~fifo_setup_signal & ~areset;
    grant_vec = '0;
    grant_any = 1'b0;
    winner    = last_grant_q;
    cand      = '0;
    for (int k = 1; k <= NUM_REQUESTERS; k++) begin
      cand = ID_WIDTH'((int'(last_grant_q) + k) % NUM_REQUESTERS);
      if (can_grant && !grant_any && arb.arbiter_req_in_valid[cand]) begin
        grant_any       = 1'b1;
        winner          = cand;
        grant_vec[cand] = 1'b1;
      end
    end
  end

  // Payload and ID carry no reset; only the valid/idle flags and the pointer do.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      out_valid_q  <= 1'b0;
      idle_q       <= 1'b1;
      last_grant_q <= ID_WIDTH'(NUM_REQUESTERS - 1);
    end else begin
      out_valid_q <= grant_any;
      idle_q      <= ~|arb.arbiter_req_in_valid & ~out_valid_q;
      if (grant_any) last_grant_q <= winner;
    end
    if (grant_any) begin
      arb.arbiter_req_out_payload <= arb.arbiter_req_in_payload[winner];
      out_id_q                    <= winner;
    end
  end

  assign arb.arbiter_grant_out     = grant_vec;
  assign arb.arbiter_req_out_valid = out_valid_q;
  assign arb.arbiter_req_out_id    = out_id_q;
  assign arbiter_idle              = idle_q;

`ifdef GLAY_ARBITER_STATS_EN
  logic [COUNTER_WIDTH-1:0] count_q [NUM_REQUESTERS];
  logic                     stats_clear;

  assign stats_clear = (state_q == ARB_IDLE) && (state_d == ARB_BUSY);

  // Counters saturate rather than wrap so long profiling runs never read low.
  always_ff @(posedge ap_clk) begin
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (areset || stats_clear)
        count_q[i] <= '0;
      else if (grant_vec[i] && (count_q[i] != '1))
        count_q[i] <= count_q[i] + COUNTER_WIDTH'(1);
    end
  end

  assign arbiter_grant_count = count_q;
`else
  always_comb begin
    for (int i = 0; i < NUM_REQUESTERS; i++) arbiter_grant_count[i] = '0;
  end
`endif

endmodule
